// File: rtl/key_debounce.sv
// Debounces one raw active-low push-button into press/release/long-press pulses,
// a clean level and a wrapping press count.
module key_debounce #(
  parameter int unsigned DEB_CYC  = 655360,
  parameter int unsigned LONG_CYC = 32768000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       key_press,
  output logic       key_release,
  output logic       key_long,
  output logic       key_level,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic             sync_q, key_s;
  logic [CNT_W-1:0] deb_cnt, deb_nx;
  logic [CNT_W-1:0] long_cnt, long_nx;
  logic             long_done, done_nx;
  logic             press_nx, release_nx, long_pulse_nx, level_nx;
  logic [7:0]       cnt_nx;

  // Two-flop synchronizer; resets to released so leaving reset never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      key_s  <= 1'b1;
    end else begin
      sync_q <= key_n;
      key_s  <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      long_cnt    <= '0;
      long_done   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_level   <= 1'b0;
      press_cnt   <= 8'd0;
    end else begin
      state       <= state_nx;
      deb_cnt     <= deb_nx;
      long_cnt    <= long_nx;
      long_done   <= done_nx;
      key_press   <= press_nx;
      key_release <= release_nx;
      key_long    <= long_pulse_nx;
      key_level   <= level_nx;
      press_cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    deb_nx        = deb_cnt;
    long_nx       = long_cnt;
    done_nx       = long_done;
    press_nx      = 1'b0;
    release_nx    = 1'b0;
    long_pulse_nx = 1'b0;
    level_nx      = key_level;
    cnt_nx        = press_cnt;

    case (state)
      IDLE: begin
        level_nx = 1'b0;
        if (!key_s) begin
          state_nx = PRESS_WAIT;
          deb_nx   = CNT_ONE;
        end else begin
          deb_nx   = '0;
        end
      end

      PRESS_WAIT: begin
        if (key_s) begin
          state_nx = IDLE;
          deb_nx   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx = HELD;
          deb_nx   = '0;
          press_nx = 1'b1;
          level_nx = 1'b1;
          cnt_nx   = press_cnt + 8'd1;
        end else begin
          deb_nx   = deb_cnt + CNT_ONE;
        end
      end

      HELD: begin
        level_nx = 1'b1;
        // Long-press fires once per press, on the held count reaching its end
        if (long_cnt == LONG_LAST && !long_done) begin
          long_pulse_nx = 1'b1;
          done_nx       = 1'b1;
        end
        if (key_s) begin
          state_nx = REL_WAIT;
          deb_nx   = CNT_ONE;
        end else if (long_cnt != LONG_LAST) begin
          long_nx  = long_cnt + CNT_ONE;
        end
      end

      REL_WAIT: begin
        level_nx = 1'b1;
        if (!key_s) begin
          state_nx = HELD;
          deb_nx   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx   = IDLE;
          deb_nx     = '0;
          release_nx = 1'b1;
          level_nx   = 1'b0;
          long_nx    = '0;
          done_nx    = 1'b0;
        end else begin
          deb_nx     = deb_cnt + CNT_ONE;
        end
      end

      default: begin
        state_nx = IDLE;
        deb_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed test-plan sequences plus random bouncing,
// every cycle compared against a run-length reference model.
module tb_key_debounce;

  localparam int unsigned DEB_CYC  = 4;
  localparam int unsigned LONG_CYC = 10;
  localparam int unsigned CNT_W    = 26;

  logic       clk;
  logic       rst;
  logic       key_n;
  logic       key_press, key_release, key_long, key_level;
  logic [7:0] press_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int n_press = 0;
  int n_rel   = 0;

  key_debounce #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .key_press(key_press), .key_release(key_release), .key_long(key_long),
    .key_level(key_level), .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level flips once DEB_CYC consecutive synchronized samples
  // disagree with it; hold time accrues only while fully settled in the pressed level.
  logic       m_s1, m_ks, m_level, m_done, m_pressed;
  int         m_run, m_hold;
  logic       e_press, e_rel, e_long, e_level;
  logic [7:0] e_cnt;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_s1 = 1'b1; m_ks = 1'b1; m_level = 1'b0; m_done = 1'b0;
      m_run = 0; m_hold = 0;
      e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_level = 1'b0; e_cnt = 8'd0;
    end else begin
      m_pressed = ~m_ks;
      e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
      if (m_level && m_run == 0 && m_hold == int'(LONG_CYC) - 1 && !m_done) begin
        e_long = 1'b1;
        m_done = 1'b1;
      end
      if (m_pressed == m_level) begin
        if (m_level && m_run == 0 && m_hold < int'(LONG_CYC) - 1) m_hold++;
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == int'(DEB_CYC)) begin
          m_level = ~m_level;
          m_run = 0;
          if (m_level) begin
            e_press = 1'b1;
            e_cnt++;
          end else begin
            e_rel = 1'b1;
            m_hold = 0;
            m_done = 1'b0;
          end
        end
      end
      e_level = m_level;
      m_ks = m_s1;
      m_s1 = key_n;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance to the next falling edge and compare every output with the model
  task automatic cyc();
    @(negedge clk);
    chk("m_press",   32'(key_press),   32'(e_press));
    chk("m_release", 32'(key_release), 32'(e_rel));
    chk("m_long",    32'(key_long),    32'(e_long));
    chk("m_level",   32'(key_level),   32'(e_level));
    chk("m_cnt",     32'(press_cnt),   32'(e_cnt));
    chk("exclusive", 32'({key_press, key_release, key_long} inside {3'b000, 3'b001, 3'b010, 3'b100}), 32'd1);
    n_press += int'(key_press);
    n_rel   += int'(key_release);
  endtask

  task automatic idle_cycles(input int n);
    key_n = 1'b1;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_press",   32'(key_press),   32'd0);
    chk("rst_release", 32'(key_release), 32'd0);
    chk("rst_long",    32'(key_long),    32'd0);
    chk("rst_level",   32'(key_level),   32'd0);
    chk("rst_cnt",     32'(press_cnt),   32'd0);
    rst = 1'b0;
  endtask

  int         rlen;
  int         p0, r0;
  logic [7:0] cnt0;

  initial begin
    rst = 1'b1;
    key_n = 1'b1;
    do_reset();
    idle_cycles(4);

    // Clean press, 20-cycle hold, clean release; index i = posedge number
    key_n = 1'b0;
    for (int i = 0; i <= 25; i++) begin
      cyc();
      chk("clean_press", 32'(key_press), 32'(i == 5));
      chk("clean_level", 32'(key_level), 32'(i >= 5));
      chk("long_once",   32'(key_long),  32'(i == 15));
    end
    chk("clean_cnt", 32'(press_cnt), 32'd1);
    key_n = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      cyc();
      chk("clean_release", 32'(key_release), 32'(i == 5));
      chk("release_level", 32'(key_level),   32'(i < 5));
    end
    idle_cycles(3);

    // Press bounce: low 2, high 1, then low steady
    for (int i = 0; i <= 11; i++) begin
      key_n = (i == 2) ? 1'b1 : 1'b0;
      cyc();
      chk("bounce_press", 32'(key_press), 32'(i == 8));
    end
    chk("bounce_cnt", 32'(press_cnt), 32'd2);
    idle_cycles(8);

    // Release bounce while held: key_long slips by the three frozen edges
    for (int i = 0; i <= 22; i++) begin
      key_n = (i == 8 || i == 9) ? 1'b1 : 1'b0;
      cyc();
      chk("rb_no_release", 32'(key_release), 32'd0);
      chk("rb_level",      32'(key_level),   32'(i >= 5));
      chk("rb_long",       32'(key_long),    32'(i == 18));
    end
    idle_cycles(8);

    // Random bouncing runs of mixed length
    for (int r = 0; r < 80; r++) begin
      key_n = ~key_n;
      rlen = int'($urandom_range(1, 16));
      for (int i = 0; i < rlen; i++) cyc();
    end
    idle_cycles(12);

    // Wrap: 256 clean press/release pairs from a fresh reset
    do_reset();
    idle_cycles(2);
    p0 = n_press;
    r0 = n_rel;
    for (int k = 0; k < 256; k++) begin
      key_n = 1'b0;
      for (int i = 0; i < 7; i++) cyc();
      key_n = 1'b1;
      for (int i = 0; i < 7; i++) cyc();
    end
    chk("wrap_cnt",     32'(press_cnt),     32'd0);
    chk("wrap_presses", 32'(n_press - p0),  32'd256);
    chk("wrap_release", 32'(n_rel - r0),    32'd256);

    // Reset mid-hold: outputs clear without waiting for a clock edge
    cnt0 = press_cnt;
    key_n = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("pre_rst_level", 32'(key_level), 32'd1);
    chk("pre_rst_cnt",   32'(press_cnt), 32'(cnt0 + 8'd1));
    #2 rst = 1'b1;
    #1;
    chk("async_level",   32'(key_level),   32'd0);
    chk("async_cnt",     32'(press_cnt),   32'd0);
    chk("async_press",   32'(key_press),   32'd0);
    chk("async_release", 32'(key_release), 32'd0);
    chk("async_long",    32'(key_long),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("post_rst_press",   32'(key_press),   32'(i == 6));
      chk("post_rst_release", 32'(key_release), 32'd0);
    end
    chk("post_rst_cnt", 32'(press_cnt), 32'd1);
    idle_cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions one raw, active-low mechanical push-button input into clean single-cycle event pulses.
- Sits directly upstream of the PWM burst generator; key_press drives that block's en input.
- Also reports release, long-press, a debounced level and a running press count for LED/UI logic.
- Runs on the 32.768 MHz system clock.

Parameters:
DEB_CYC, 655360, consecutive stable cycles required to accept a level change (20 ms at 32.768 MHz); legal range >= 2
LONG_CYC, 32768000, cycles of continuous accepted hold before key_long fires (1 s); must be > DEB_CYC
CNT_W, 26, width of both internal counters; must hold LONG_CYC-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
key_n  input  1  raw button, asynchronous to clk, 0 = pressed
key_press  output  1  one-cycle pulse on accepted press
key_release  output  1  one-cycle pulse on accepted release
key_long  output  1  one-cycle pulse, at most once per press, after LONG_CYC cycles held
key_level  output  1  debounced state, 1 = pressed
press_cnt  output  8  count of accepted presses, wraps 255 -> 0

Behaviour:
- Reset: all outputs 0, press_cnt 0, state IDLE, counters 0. Both synchronizer flops reset to 1 (released), so no spurious press on exit.
- Reset asserted mid-operation aborts immediately. No release pulse is emitted.
- Synchronizer: 2-flop chain on key_n gives key_s. If key_n is sampled low at edge 0, key_s is low after edge 1.
- deb_cnt counts consecutive qualifying cycles. It clears on any disqualifying sample and on every state change.
- FSM states:
  - IDLE: key_level=0. key_s==0 -> PRESS_WAIT; deb_cnt=1 on that edge.
  - PRESS_WAIT: key_s==1 -> IDLE (bounce rejected, no pulse). key_s==0 and deb_cnt==DEB_CYC-1 -> HELD; key_press=1 for the next cycle; press_cnt+1. Otherwise deb_cnt+1.
  - HELD: key_level=1. Increments long_cnt while key_s==0. When long_cnt reaches LONG_CYC-1 and long_done==0: key_long=1 for one cycle, long_done=1. key_s==1 -> REL_WAIT; deb_cnt=1.
  - REL_WAIT: key_level stays 1; long_cnt frozen. key_s==0 -> HELD (release bounce rejected, no pulse; long_cnt resumes). key_s==1 and deb_cnt==DEB_CYC-1 -> IDLE; key_release=1 for the next cycle; long_cnt=0; long_done=0.
- Press latency: clean press sampled at edge 0 gives key_press high after edge DEB_CYC+1, for exactly one cycle.
- Release latency is symmetric.
- key_level rises on the same edge as key_press. It falls on the same edge as key_release.
- key_press, key_release and key_long are registered and mutually exclusive in any cycle.
- key_long never fires in the same cycle as key_press, since LONG_CYC > DEB_CYC.
- press_cnt wrap is silent; there is no overflow flag.
- Counters saturate rather than wrap:
  - long_cnt stops at LONG_CYC-1.
  - deb_cnt never exceeds DEB_CYC-1.

Test Plan (DEB_CYC=4, LONG_CYC=10):
- Clean press: key_n low at edge 0, held -> key_press high only after edge 5; key_level=1 from edge 5; press_cnt=1.
- Press bounce: key_n low 2 cycles, high 1, low steady -> no pulse during bounce; key_press fires 5 edges after final low sample; press_cnt=1.
- Long hold: hold 20 cycles after accept, then release cleanly -> key_long once, 10 cycles after key_press; key_release 5 edges after key_n rises; key_level 0.
- Release bounce: while HELD, key_n high 2 cycles then low -> no key_release; key_level stays 1; key_long timing delayed only by the frozen cycles.
- Wrap: 256 clean press/release pairs -> press_cnt returns to 0; exactly 256 key_press and 256 key_release pulses.
- Reset mid-hold: assert rst in HELD -> all outputs 0 asynchronously; with key_n still low after rst drops, a fresh key_press after DEB_CYC+2 edges.
